add_sub_sequencer: RTL and testbench

//  Operator-entry controller for the 7-bit add/sub datapath. It steps through these phases:
//  - entry of operand A in two chunks, then operand B in two chunks, then the op select;
//  - a one-cycle execute, then hold of the result.

---
 rtl/add_sub_sequencer_pkg.sv | 18 +
 rtl/add_sub_sequencer_core.sv | 21 ++
 rtl/add_sub_sequencer.sv | 149 ++++++++++++++
 tb/tb_add_sub_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/add_sub_sequencer_pkg.sv
// Shared state encoding and op-select codes for the add/sub operator-entry sequencer.
package add_sub_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_A_HI   = 3'd1,
    ST_A_LO   = 3'd2,
    ST_B_HI   = 3'd3,
    ST_B_LO   = 3'd4,
    ST_OP     = 3'd5,
    ST_EXEC   = 3'd6,
    ST_RESULT = 3'd7
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_sub_sequencer_core.sv
// Combinational WIDTH-bit adder; subtract is A + ~B + 1, so carry-out reads as no-borrow.
module add_sub_core #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  assign b_eff = sub_i ? ~b_i : b_i;
  assign full  = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};

  assign sum_o   = full[WIDTH-1:0];
  assign carry_o = full[WIDTH];

endmodule

// File: rtl/add_sub_sequencer.sv
// Operator-entry sequencer: latches A/B chunks and op from rotary pulses, executes once, holds result.
//
//  state  | meaning
//  IDLE   | waiting for a confirm pulse to start entry
//  A_HI   | entering A upper chunk
//  A_LO   | entering A lower nibble
//  B_HI   | entering B upper chunk
//  B_LO   | entering B lower nibble
//  OP     | selecting add/sub
//  EXEC   | one-cycle compute
//  RESULT | holding sum/carry
module add_sub_sequencer
  import add_sub_sequencer_pkg::*;
#(
  parameter int WIDTH       = 7,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rot_event,
  input  logic             rot_dir,
  input  logic [3:0]       slide,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             result_valid,
  output logic [2:0]       phase,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_EXPIRE = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             op_q, op_d, carry_q, carry_d, timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] core_sum;
  logic             core_carry;
  logic             in_entry, fwd, back;

  add_sub_core #(.WIDTH(WIDTH)) u_core (
    .a_i     (a_q),
    .b_i     (b_q),
    .sub_i   (op_q),
    .sum_o   (core_sum),
    .carry_o (core_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_ADD;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_entry = (state_q == ST_A_HI) || (state_q == ST_A_LO) || (state_q == ST_B_HI) ||
                    (state_q == ST_B_LO) || (state_q == ST_OP);
  assign fwd  = rot_event &  rot_dir;
  assign back = rot_event & ~rot_dir;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    timeout_d = rot_event ? 1'b0 : timeout_q;
    cnt_d     = (rot_event || !in_entry) ? '0 : cnt_q + CNT_W'(1);

    // A rot_event on the expiry cycle takes priority over the abort.
    if (in_entry && !rot_event && cnt_q == CNT_EXPIRE) begin
      state_d   = ST_IDLE;
      a_d       = '0;
      b_d       = '0;
      timeout_d = 1'b1;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (fwd) state_d = ST_A_HI;
        ST_A_HI: begin
          if (fwd) begin
            a_d[WIDTH-1:4] = slide[WIDTH-5:0];
            state_d        = ST_A_LO;
          end else if (back) state_d = ST_IDLE;
        end
        ST_A_LO: begin
          if (fwd) begin
            a_d[3:0] = slide;
            state_d  = ST_B_HI;
          end else if (back) state_d = ST_A_HI;
        end
        ST_B_HI: begin
          if (fwd) begin
            b_d[WIDTH-1:4] = slide[WIDTH-5:0];
            state_d        = ST_B_LO;
          end else if (back) state_d = ST_A_LO;
        end
        ST_B_LO: begin
          if (fwd) begin
            b_d[3:0] = slide;
            state_d  = ST_OP;
          end else if (back) state_d = ST_B_HI;
        end
        ST_OP: begin
          if (fwd) begin
            op_d    = slide[0];
            state_d = ST_EXEC;
          end else if (back) state_d = ST_B_LO;
        end
        ST_EXEC: begin
          sum_d   = core_sum;
          carry_d = core_carry;
          state_d = ST_RESULT;
        end
        ST_RESULT: begin
          if (fwd) state_d = ST_A_HI;
          else if (back) state_d = ST_OP;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    phase        = state_q;
    result_valid = (state_q == ST_RESULT);
  end

  assign sum     = sum_q;
  assign carry   = carry_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_add_sub_sequencer.sv
// Directed bench for add_sub_sequencer with a short timeout; expected values are hand-computed.
module tb_add_sub_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rot_event = 1'b0;
  logic       rot_dir = 1'b0;
  logic [3:0] slide = 4'h0;
  logic [6:0] sum;
  logic       carry, result_valid, timeout;
  logic [2:0] phase;

  int n_cmp = 0;
  int n_err = 0;

  add_sub_sequencer #(.WIDTH(7), .TIMEOUT_CYC(16), .CNT_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rot_event    (rot_event),
    .rot_dir      (rot_dir),
    .slide        (slide),
    .sum          (sum),
    .carry        (carry),
    .result_valid (result_valid),
    .phase        (phase),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; event is sampled on the next rising edge, returns at the following falling edge.
  task automatic pulse(input logic dir, input logic [3:0] sl);
    rot_event = 1'b1;
    rot_dir   = dir;
    slide     = sl;
    @(negedge clk);
    rot_event = 1'b0;
  endtask

  task automatic step(input logic dir, input logic [3:0] sl);
    pulse(dir, sl);
    @(negedge clk);
  endtask

  task automatic chk_result(input string tag, input logic [6:0] s, input logic c);
    chk({tag, "_sum"}, {1'b0, sum}, {1'b0, s});
    chk({tag, "_carry"}, {7'd0, carry}, {7'd0, c});
    chk({tag, "_rv"}, {7'd0, result_valid}, 8'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_phase", {5'd0, phase}, 8'd0);
    chk("rst_sum", {1'b0, sum}, 8'd0);
    chk("rst_carry", {7'd0, carry}, 8'd0);
    chk("rst_rv", {7'd0, result_valid}, 8'd0);
    chk("rst_timeout", {7'd0, timeout}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: async reset mid-B_HI with A = 0x35 latched
    step(1'b1, 4'h0);
    step(1'b1, 4'h3);
    step(1'b1, 4'h5);
    chk("t1_phase_bhi", {5'd0, phase}, 8'd3);
    chk("t1_a_latched", {1'b0, dut.a_q}, 8'h35);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_phase", {5'd0, phase}, 8'd0);
    chk("t1_a_clr", {1'b0, dut.a_q}, 8'h00);
    chk("t1_sum", {1'b0, sum}, 8'd0);
    chk("t1_rv", {7'd0, result_valid}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 2: 0x35 + 0x12
    step(1'b1, 4'h0);
    step(1'b1, 4'h3);
    step(1'b1, 4'h5);
    step(1'b1, 4'h1);
    step(1'b1, 4'h2);
    chk("t2_phase_op", {5'd0, phase}, 8'd5);
    pulse(1'b1, 4'h0);
    chk("t2_phase_exec", {5'd0, phase}, 8'd6);
    chk("t2_rv_early", {7'd0, result_valid}, 8'd0);
    @(negedge clk);
    chk("t2_phase_res", {5'd0, phase}, 8'd7);
    chk_result("t2", 7'h47, 1'b0);

    // 3: back to OP, subtract
    step(1'b0, 4'h0);
    chk("t3_phase_op", {5'd0, phase}, 8'd5);
    chk("t3_rv_low", {7'd0, result_valid}, 8'd0);
    chk("t3_sum_hold", {1'b0, sum}, 8'h47);
    pulse(1'b1, 4'h1);
    @(negedge clk);
    chk_result("t3", 7'h23, 1'b1);

    // 4a: 0x05 - 0x0A wraps
    step(1'b1, 4'h0);
    chk("t4_phase_ahi", {5'd0, phase}, 8'd1);
    chk("t4_sum_keep", {1'b0, sum}, 8'h23);
    step(1'b1, 4'h0);
    step(1'b1, 4'h5);
    step(1'b1, 4'h0);
    step(1'b1, 4'hA);
    pulse(1'b1, 4'h1);
    @(negedge clk);
    chk_result("t4a", 7'h7B, 1'b0);

    // 4b: 0x7F + 0x01 overflows
    step(1'b1, 4'h0);
    step(1'b1, 4'h7);
    step(1'b1, 4'hF);
    step(1'b1, 4'h0);
    step(1'b1, 4'h1);
    pulse(1'b1, 4'h0);
    @(negedge clk);
    chk_result("t4b", 7'h00, 1'b1);

    // 5: back-step and re-enter A hi; A = 0x25, B = 0x00
    step(1'b1, 4'h0);
    step(1'b1, 4'h3);
    step(1'b0, 4'h0);
    chk("t5_phase_back", {5'd0, phase}, 8'd1);
    step(1'b1, 4'h2);
    step(1'b1, 4'h5);
    step(1'b1, 4'h0);
    step(1'b1, 4'h0);
    pulse(1'b1, 4'h0);
    @(negedge clk);
    chk_result("t5", 7'h25, 1'b0);
    step(1'b1, 4'h0);
    step(1'b0, 4'h0);
    chk("t5_ahi_back_idle", {5'd0, phase}, 8'd0);
    step(1'b0, 4'h0);
    chk("t5_idle_stays", {5'd0, phase}, 8'd0);

    // 6: stall in B_LO until abort
    step(1'b1, 4'h0);
    step(1'b1, 4'h1);
    step(1'b1, 4'h1);
    pulse(1'b1, 4'h1);
    repeat (15) @(negedge clk);
    chk("t6_before_expiry", {5'd0, phase}, 8'd4);
    chk("t6_no_timeout_yet", {7'd0, timeout}, 8'd0);
    @(negedge clk);
    chk("t6_abort_phase", {5'd0, phase}, 8'd0);
    chk("t6_timeout", {7'd0, timeout}, 8'd1);
    chk("t6_sum_hold", {1'b0, sum}, 8'h25);
    chk("t6_carry_hold", {7'd0, carry}, 8'd0);
    chk("t6_a_clr", {1'b0, dut.a_q}, 8'h00);
    chk("t6_b_clr", {1'b0, dut.b_q}, 8'h00);
    repeat (3) @(negedge clk);
    chk("t6_timeout_sticky", {7'd0, timeout}, 8'd1);
    pulse(1'b1, 4'h0);
    chk("t6_clear_timeout", {7'd0, timeout}, 8'd0);
    chk("t6_clear_phase", {5'd0, phase}, 8'd1);
    repeat (15) @(negedge clk);
    chk("t6_edge_phase", {5'd0, phase}, 8'd1);
    pulse(1'b1, 4'h3);
    chk("t6_race_phase", {5'd0, phase}, 8'd2);
    chk("t6_race_timeout", {7'd0, timeout}, 8'd0);
    chk("t6_race_a_hi", {1'b0, dut.a_q}, 8'h30);

    // reset clears a non-zero result
    #2 rst_n = 1'b0;
    #1;
    chk("end_rst_sum", {1'b0, sum}, 8'd0);
    chk("end_rst_phase", {5'd0, phase}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
